// File: rtl/csrisc_pkg.sv
// ---------------------------------------------------------------------------
// csrisc_pkg
//   Shared definitions for the csRISC front end.
//   - XLEN              : architectural address/instruction width
//   - RESET_PC_DEFAULT  : default PC loaded at reset (word aligned)
//   - fetch_state_e     : fetch sequencer state encoding
//   - misaligned()      : true when the two low address bits are non-zero
// ---------------------------------------------------------------------------
package csrisc_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = '0;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_FETCH = 2'd1,
    ST_HOLD  = 2'd2,
    ST_HALT  = 2'd3
  } fetch_state_e;

  function automatic logic misaligned(input logic [1:0] lsb);
    return |lsb;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl_if
//   Instruction-memory fetch bus between the fetch sequencer and imem.
//   imem_addr  : fetch address (always equal to the current PC)
//   imem_req   : fetch request; once raised it stays high until imem_ready
//   imem_ready : imem returns instr_in this cycle (only meaningful with req)
//   instr_in   : instruction word returned by imem
//   master = fetch sequencer side, slave = instruction memory side.
// ---------------------------------------------------------------------------
interface pc_fetch_ctrl_if #(
  parameter int XLEN = csrisc_pkg::XLEN
) ();

  logic [XLEN-1:0] imem_addr;
  logic            imem_req;
  logic            imem_ready;
  logic [XLEN-1:0] instr_in;

  modport master (
    output imem_addr,
    output imem_req,
    input  imem_ready,
    input  instr_in
  );

  modport slave (
    input  imem_addr,
    input  imem_req,
    output imem_ready,
    output instr_in
  );

endinterface

// File: rtl/pc_next_mux.sv
// ---------------------------------------------------------------------------
// pc_next_mux
//   Combinational next-PC selection for the fetch sequencer.
//   Priority: halt > jump > branch_taken > pc_add.
//   Inputs : halt, jump/jump_target, branch_taken/branch_target, pc, pc_add
//   Outputs: next_pc   - selected PC (redirect targets forced word aligned)
//            redirect  - a jump/branch was selected (halt suppresses it)
//            align_err - the selected redirect target had [1:0] != 0
// ---------------------------------------------------------------------------
module pc_next_mux #(
  parameter int XLEN = csrisc_pkg::XLEN
) (
  input  logic            halt,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] pc_add,
  output logic [XLEN-1:0] next_pc,
  output logic            redirect,
  output logic            align_err
);

  import csrisc_pkg::*;

  always_comb begin
    next_pc   = pc_add;
    redirect  = 1'b0;
    align_err = 1'b0;
    if (halt) begin
      // A halt freezes the PC even if a redirect arrives alongside it.
      next_pc = pc;
    end else if (jump) begin
      next_pc   = {jump_target[XLEN-1:2], 2'b00};
      redirect  = 1'b1;
      align_err = misaligned(jump_target[1:0]);
    end else if (branch_taken) begin
      next_pc   = {branch_target[XLEN-1:2], 2'b00};
      redirect  = 1'b1;
      align_err = misaligned(branch_target[1:0]);
    end
  end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
//   Program-counter register and instruction-fetch sequencer of csRISC.
//   Holds the PC, runs the req/ready fetch handshake on the imem bus and
//   hands one instruction per completed fetch to decode.
//
//   Parameters
//     XLEN       address/instruction width
//     RESET_PC   PC value loaded at reset (word aligned)
//   Ports
//     clk, rst_n      core clock (rising edge), async active-low reset
//     pc              current PC, to the external pc_adder and imem
//     pc_add          pc+4 from the external pc_adder
//     branch_taken/branch_target, jump/jump_target   redirect requests
//     stall           decode cannot accept an instruction
//     halt_req        stop fetching until reset
//     bus             imem fetch bus (master side)
//     instr_out, instr_pc, instr_valid   instruction strobe to decode
//     align_err       1-cycle pulse: redirect target was not word aligned
//     halted          sequencer is halted
// ---------------------------------------------------------------------------
module pc_fetch_ctrl #(
  parameter int              XLEN     = csrisc_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = csrisc_pkg::RESET_PC_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst_n,
  output logic [XLEN-1:0]        pc,
  input  logic [XLEN-1:0]        pc_add,
  input  logic                   branch_taken,
  input  logic [XLEN-1:0]        branch_target,
  input  logic                   jump,
  input  logic [XLEN-1:0]        jump_target,
  input  logic                   stall,
  input  logic                   halt_req,
  pc_fetch_ctrl_if.master        bus,
  output logic [XLEN-1:0]        instr_out,
  output logic                   instr_valid,
  output logic [XLEN-1:0]        instr_pc,
  output logic                   align_err,
  output logic                   halted
);

  import csrisc_pkg::*;

  fetch_state_e    state;
  logic [XLEN-1:0] pc_r;
  logic            req_r;
  logic            halt_pend;
  logic            drop_pend;
  logic            align_r;
  logic            halted_r;

  logic [XLEN-1:0] buf_p0;
  logic [XLEN-1:0] instr_p1;
  logic [XLEN-1:0] instr_pc_p1;
  logic            vld_p1;

  logic            halt_any;
  logic [XLEN-1:0] next_pc;
  logic            redirect;
  logic            align_flag;

  // A halt request is remembered until the outstanding fetch finishes.
  assign halt_any = halt_req | halt_pend;

  pc_next_mux #(.XLEN(XLEN)) u_pc_next_mux (
    .halt          (halt_any),
    .jump          (jump),
    .jump_target   (jump_target),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .pc            (pc_r),
    .pc_add        (pc_add),
    .next_pc       (next_pc),
    .redirect      (redirect),
    .align_err     (align_flag)
  );

  // ---- stage p0: fetch return captured into the hold buffer ----
  // Plain data register: only read in HOLD, which is entered on the very
  // cycle this capture happens, so no reset is needed.
  always_ff @(posedge clk) begin
    if (req_r && bus.imem_ready) begin
      buf_p0 <= bus.instr_in;
    end
  end

  // ---- stage p1: sequencer, PC register and decode strobe ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_BOOT;
      pc_r        <= RESET_PC;
      req_r       <= 1'b0;
      halt_pend   <= 1'b0;
      drop_pend   <= 1'b0;
      align_r     <= 1'b0;
      halted_r    <= 1'b0;
      vld_p1      <= 1'b0;
      instr_p1    <= '0;
      instr_pc_p1 <= '0;
    end else begin
      vld_p1  <= 1'b0;
      align_r <= 1'b0;
      unique case (state)
        ST_BOOT: begin
          if (halt_any) begin
            state    <= ST_HALT;
            halted_r <= 1'b1;
          end else begin
            state <= ST_FETCH;
            req_r <= 1'b1;
            if (redirect) begin
              pc_r    <= next_pc;
              align_r <= align_flag;
            end
          end
        end

        ST_FETCH: begin
          if (bus.imem_ready) begin
            drop_pend <= 1'b0;
            if (halt_any) begin
              // Outstanding fetch done; its data is thrown away.
              state     <= ST_HALT;
              req_r     <= 1'b0;
              halted_r  <= 1'b1;
              halt_pend <= 1'b0;
            end else if (redirect) begin
              // Redirect beats the returning instruction; req stays high
              // so the next fetch starts at the new PC right away.
              pc_r    <= next_pc;
              align_r <= align_flag;
            end else if (!drop_pend) begin
              if (stall) begin
                state <= ST_HOLD;
                req_r <= 1'b0;
              end else begin
                instr_p1    <= bus.instr_in;
                instr_pc_p1 <= pc_r;
                vld_p1      <= 1'b1;
                pc_r        <= next_pc;
              end
            end
            // With drop_pend set, pc_r already holds the redirect target,
            // so the stale return is simply ignored and fetching resumes.
          end else if (halt_any) begin
            halt_pend <= 1'b1;
          end else if (redirect) begin
            // The request in flight must still complete; mark its data stale.
            pc_r      <= next_pc;
            align_r   <= align_flag;
            drop_pend <= 1'b1;
          end
        end

        ST_HOLD: begin
          if (halt_any) begin
            state    <= ST_HALT;
            halted_r <= 1'b1;
          end else if (redirect) begin
            // Buffered instruction is discarded.
            pc_r    <= next_pc;
            align_r <= align_flag;
            state   <= ST_FETCH;
            req_r   <= 1'b1;
          end else if (!stall) begin
            instr_p1    <= buf_p0;
            instr_pc_p1 <= pc_r;
            vld_p1      <= 1'b1;
            pc_r        <= next_pc;
            state       <= ST_FETCH;
            req_r       <= 1'b1;
          end
        end

        ST_HALT: begin
          // Frozen until reset.
        end
      endcase
    end
  end

  assign pc            = pc_r;
  assign bus.imem_addr = pc_r;
  assign bus.imem_req  = req_r;
  assign instr_out     = instr_p1;
  assign instr_pc      = instr_pc_p1;
  assign instr_valid   = vld_p1;
  assign align_err     = align_r;
  assign halted        = halted_r;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_ctrl
//   Self-checking bench for pc_fetch_ctrl: a directed cycle table, a halt /
//   reset sequence and a randomized run checked against a program-order model.
// ---------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] pc;
  logic [31:0] pc_add;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = '0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = '0;
  logic        stall = 1'b0;
  logic        halt_req = 1'b0;
  logic        rdy = 1'b0;
  logic [31:0] instr_out;
  logic        instr_valid;
  logic [31:0] instr_pc;
  logic        align_err;
  logic        halted;

  int n_vec = 0;
  int n_err = 0;

  pc_fetch_ctrl_if #(.XLEN(32)) bus ();

  // Instruction memory content is a fixed function of the address.
  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return a ^ 32'hC0DE_0000;
  endfunction

  assign pc_add         = pc + 32'd4;
  assign bus.imem_ready = rdy;
  assign bus.instr_in   = mem_f(bus.imem_addr);

  pc_fetch_ctrl #(.XLEN(32), .RESET_PC(RST_PC)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .pc            (pc),
    .pc_add        (pc_add),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .stall         (stall),
    .halt_req      (halt_req),
    .bus           (bus),
    .instr_out     (instr_out),
    .instr_valid   (instr_valid),
    .instr_pc      (instr_pc),
    .align_err     (align_err),
    .halted        (halted)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // One clock: inputs set before the rising edge, outputs sampled at the
  // following falling edge.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic clear_inputs();
    rdy = 1'b0; stall = 1'b0; jump = 1'b0; branch_taken = 1'b0;
    halt_req = 1'b0; jump_target = '0; branch_target = '0;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic        rdy;
    logic        stl;
    logic        jmp;
    logic [31:0] jt;
    logic        br;
    logic [31:0] bt;
    logic [31:0] e_pc;
    logic        e_req;
    logic        e_vld;
    logic [31:0] e_ipc;
    logic        e_aln;
  } vec_t;

  vec_t tbl [25];

  // Random-phase model state: next program-order PC decode should see.
  logic [31:0] exp_next;
  logic [31:0] tgt;
  logic        redir;
  int          n_del;

  initial begin
    // rdy stl jmp jt br bt | pc req vld ipc aln
    tbl[0]  = '{1'b0,1'b0,1'b0,32'h0,1'b0,32'h0, 32'h000,1'b1,1'b0,32'h0,1'b0};
    tbl[1]  = '{1'b1,1'b0,1'b0,32'h0,1'b0,32'h0, 32'h004,1'b1,1'b1,32'h000,1'b0};
    tbl[2]  = '{1'b1,1'b0,1'b0,32'h0,1'b0,32'h0, 32'h008,1'b1,1'b1,32'h004,1'b0};
    tbl[3]  = '{1'b1,1'b0,1'b0,32'h0,1'b0,32'h0, 32'h00C,1'b1,1'b1,32'h008,1'b0};
    tbl[4]  = '{1'b1,1'b1,1'b0,32'h0,1'b0,32'h0, 32'h00C,1'b0,1'b0,32'h0,1'b0};
    tbl[5]  = '{1'b1,1'b1,1'b0,32'h0,1'b0,32'h0, 32'h00C,1'b0,1'b0,32'h0,1'b0};
    tbl[6]  = '{1'b0,1'b1,1'b0,32'h0,1'b0,32'h0, 32'h00C,1'b0,1'b0,32'h0,1'b0};
    tbl[7]  = '{1'b0,1'b0,1'b0,32'h0,1'b0,32'h0, 32'h010,1'b1,1'b1,32'h00C,1'b0};
    tbl[8]  = '{1'b0,1'b0,1'b0,32'h0,1'b0,32'h0, 32'h010,1'b1,1'b0,32'h0,1'b0};
    tbl[9]  = '{1'b1,1'b0,1'b0,32'h0,1'b0,32'h0, 32'h014,1'b1,1'b1,32'h010,1'b0};
    tbl[10] = '{1'b0,1'b0,1'b0,32'h0,1'b1,32'h100, 32'h100,1'b1,1'b0,32'h0,1'b0};
    tbl[11] = '{1'b0,1'b0,1'b0,32'h0,1'b0,32'h0, 32'h100,1'b1,1'b0,32'h0,1'b0};
    tbl[12] = '{1'b1,1'b0,1'b0,32'h0,1'b0,32'h0, 32'h100,1'b1,1'b0,32'h0,1'b0};
    tbl[13] = '{1'b1,1'b0,1'b0,32'h0,1'b0,32'h0, 32'h104,1'b1,1'b1,32'h100,1'b0};
    tbl[14] = '{1'b1,1'b0,1'b1,32'h200,1'b1,32'h300, 32'h200,1'b1,1'b0,32'h0,1'b0};
    tbl[15] = '{1'b1,1'b0,1'b0,32'h0,1'b0,32'h0, 32'h204,1'b1,1'b1,32'h200,1'b0};
    tbl[16] = '{1'b0,1'b0,1'b0,32'h0,1'b1,32'h103, 32'h100,1'b1,1'b0,32'h0,1'b1};
    tbl[17] = '{1'b1,1'b0,1'b0,32'h0,1'b0,32'h0, 32'h100,1'b1,1'b0,32'h0,1'b0};
    tbl[18] = '{1'b1,1'b0,1'b0,32'h0,1'b0,32'h0, 32'h104,1'b1,1'b1,32'h100,1'b0};
    tbl[19] = '{1'b1,1'b1,1'b0,32'h0,1'b0,32'h0, 32'h104,1'b0,1'b0,32'h0,1'b0};
    tbl[20] = '{1'b0,1'b1,1'b1,32'h40,1'b0,32'h0, 32'h040,1'b1,1'b0,32'h0,1'b0};
    tbl[21] = '{1'b1,1'b0,1'b0,32'h0,1'b0,32'h0, 32'h044,1'b1,1'b1,32'h040,1'b0};
    tbl[22] = '{1'b1,1'b0,1'b1,32'hFFFF_FFFC,1'b0,32'h0, 32'hFFFF_FFFC,1'b1,1'b0,32'h0,1'b0};
    tbl[23] = '{1'b1,1'b0,1'b0,32'h0,1'b0,32'h0, 32'h000,1'b1,1'b1,32'hFFFF_FFFC,1'b0};
    tbl[24] = '{1'b1,1'b0,1'b0,32'h0,1'b0,32'h0, 32'h004,1'b1,1'b1,32'h000,1'b0};

    // ---------------- reset state ----------------
    do_reset();
    #1;
    chk("rst_pc", pc, RST_PC);
    chk("rst_req", 32'(bus.imem_req), 32'd0);
    chk("rst_vld", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr_out, 32'd0);
    chk("rst_ipc", instr_pc, 32'd0);
    chk("rst_aln", 32'(align_err), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);

    // ---------------- directed cycle table ----------------
    for (int i = 0; i < 25; i++) begin
      rdy = tbl[i].rdy; stall = tbl[i].stl;
      jump = tbl[i].jmp; jump_target = tbl[i].jt;
      branch_taken = tbl[i].br; branch_target = tbl[i].bt;
      step();
      chk($sformatf("t%0d_pc", i), pc, tbl[i].e_pc);
      chk($sformatf("t%0d_req", i), 32'(bus.imem_req), 32'(tbl[i].e_req));
      chk($sformatf("t%0d_vld", i), 32'(instr_valid), 32'(tbl[i].e_vld));
      chk($sformatf("t%0d_aln", i), 32'(align_err), 32'(tbl[i].e_aln));
      if (tbl[i].e_vld) begin
        chk($sformatf("t%0d_ipc", i), instr_pc, tbl[i].e_ipc);
        chk($sformatf("t%0d_instr", i), instr_out, mem_f(tbl[i].e_ipc));
      end
    end
    chk("tbl_halted", 32'(halted), 32'd0);

    // ---------------- halt mid-fetch, halt beats jump, then reset ----------------
    do_reset();
    step();                                   // BOOT -> FETCH
    chk("h_boot_req", 32'(bus.imem_req), 32'd1);
    halt_req = 1'b1; jump = 1'b1; jump_target = 32'h500;
    step();                                   // fetch still outstanding
    chk("h_pend_pc", pc, RST_PC);
    chk("h_pend_req", 32'(bus.imem_req), 32'd1);
    chk("h_pend_halted", 32'(halted), 32'd0);
    chk("h_pend_aln", 32'(align_err), 32'd0);
    halt_req = 1'b0; jump = 1'b0; rdy = 1'b1;
    step();                                   // fetch completes, data dropped
    chk("h_halted", 32'(halted), 32'd1);
    chk("h_req", 32'(bus.imem_req), 32'd0);
    chk("h_vld", 32'(instr_valid), 32'd0);
    chk("h_pc", pc, RST_PC);
    jump = 1'b1; jump_target = 32'h601;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("h%0d_pc_frozen", i), pc, RST_PC);
      chk($sformatf("h%0d_vld", i), 32'(instr_valid), 32'd0);
      chk($sformatf("h%0d_aln", i), 32'(align_err), 32'd0);
      chk($sformatf("h%0d_halted", i), 32'(halted), 32'd1);
    end
    #2 rst_n = 1'b0;                          // asynchronous assertion
    #1;
    chk("h_rst_halted", 32'(halted), 32'd0);
    chk("h_rst_pc", pc, RST_PC);
    chk("h_rst_req", 32'(bus.imem_req), 32'd0);
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b1;

    // ---------------- randomized run vs program-order model ----------------
    do_reset();
    exp_next = RST_PC;
    n_del = 0;
    for (int c = 0; c < 3000; c++) begin
      rdy          = ($urandom_range(0, 9) < 6);
      stall        = ($urandom_range(0, 9) < 3);
      jump         = ($urandom_range(0, 24) == 0);
      branch_taken = ($urandom_range(0, 14) == 0);
      jump_target  = $urandom;
      branch_target = $urandom_range(0, 32'h0000_FFFF);
      step();
      redir = jump | branch_taken;
      tgt   = jump ? jump_target : branch_target;
      if (redir) begin
        chk("r_redir_vld", 32'(instr_valid), 32'd0);
        chk("r_aln", 32'(align_err), 32'(tgt[1:0] != 2'b00));
        chk("r_redir_pc", pc, {tgt[31:2], 2'b00});
        exp_next = {tgt[31:2], 2'b00};
      end else begin
        chk("r_aln_idle", 32'(align_err), 32'd0);
        if (instr_valid) begin
          chk("r_ipc", instr_pc, exp_next);
          chk("r_instr", instr_out, mem_f(exp_next));
          exp_next = exp_next + 32'd4;
          n_del++;
        end
      end
    end
    chk("r_progress", 32'(n_del > 200), 32'd1);
    chk("r_halted", 32'(halted), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
